// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: drives the synchronous instruction ROM from the
// free-running PC and re-aligns each returned word with its byte address.
//
// Ports
//   clka, rsta        clock / asynchronous active-high reset
//   pc_in             byte address from the program counter
//   flush             kills every in-flight fetch, including this edge's
//   rom_addra         ROM word address (combinational from pc_in)
//   rom_douta         ROM data, valid LAT edges after its address
//   if_valid          if_* outputs hold a fetched instruction
//   if_pc, if_instr   fetched word and its byte address
//   if_op .. if_funct R-type fields sliced from if_instr
//   if_rtype          valid instruction with opcode 0
//   if_misalign       entry had pc[1:0] != 0
//   if_oob            entry lies beyond the ROM
//   if_count          saturating count of good instructions delivered
module instr_fetch_stage #(
  parameter int ADDR_W = 6,
  parameter int LAT    = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic [31:0]       pc_in,
  input  logic              flush,
  output logic [ADDR_W-1:0] rom_addra,
  input  logic [31:0]       rom_douta,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic [5:0]        if_op,
  output logic [4:0]        if_rs,
  output logic [4:0]        if_rt,
  output logic [4:0]        if_rd,
  output logic [4:0]        if_shamt,
  output logic [5:0]        if_funct,
  output logic              if_rtype,
  output logic              if_misalign,
  output logic              if_oob,
  output logic [CNT_W-1:0]  if_count
);

  logic [LAT-1:0][31:0] ppc;
  logic [LAT-1:0]       pv;
  logic [LAT-1:0]       pmis;
  logic [LAT-1:0]       poob;

  logic mis_in;
  logic oob_in;
  logic t_v;
  logic t_mis;
  logic t_oob;
  logic t_err;
  logic good;

  assign rom_addra = pc_in[ADDR_W+1:2];
  assign mis_in    = (pc_in[1:0] != 2'b00);
  assign oob_in    = (pc_in[31:ADDR_W+2] != '0);

  assign t_v   = pv[LAT-1];
  assign t_mis = pmis[LAT-1];
  assign t_oob = poob[LAT-1];
  assign t_err = t_mis | t_oob;

  // A flushed tail entry never counts, even though its tag was valid.
  assign good = t_v & ~flush & ~t_err;

  // Tag pipeline: mirrors the ROM latency so each word meets its PC.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      ppc  <= '0;
      pv   <= '0;
      pmis <= '0;
      poob <= '0;
    end else begin
      ppc[0]  <= pc_in;
      pv[0]   <= ~flush;
      pmis[0] <= mis_in;
      poob[0] <= oob_in;
      for (int k = 1; k < LAT; k++) begin
        ppc[k]  <= ppc[k-1];
        pv[k]   <= pv[k-1] & ~flush;
        pmis[k] <= pmis[k-1];
        poob[k] <= poob[k-1];
      end
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_instr    <= '0;
      if_misalign <= 1'b0;
      if_oob      <= 1'b0;
    end else begin
      if_valid    <= t_v & ~flush;
      if_pc       <= ppc[LAT-1];
      if_instr    <= t_err ? 32'd0 : rom_douta;
      if_misalign <= t_mis;
      if_oob      <= t_oob;
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      if_count <= '0;
    end else if (good && (if_count != '1)) begin
      if_count <= if_count + CNT_W'(1);
    end
  end

  assign if_op    = if_instr[31:26];
  assign if_rs    = if_instr[25:21];
  assign if_rt    = if_instr[20:16];
  assign if_rd    = if_instr[15:11];
  assign if_shamt = if_instr[10:6];
  assign if_funct = if_instr[5:0];
  assign if_rtype = if_valid & (if_op == 6'd0);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: two instances (LAT=1/CNT_W=4, LAT=3/CNT_W=16)
// share one PC stream; a scoreboard queue per instance feeds its monitor.
module tb_instr_fetch_stage;

  logic        clka;
  logic        rsta;
  logic [31:0] pc_in;
  logic        flush;

  logic [5:0]  a_addr, b_addr;
  logic [31:0] a_dout, b_dout;
  logic        a_valid, b_valid;
  logic [31:0] a_pc, b_pc, a_instr, b_instr;
  logic [5:0]  a_op, b_op, a_funct, b_funct;
  logic [4:0]  a_rs, b_rs, a_rt, b_rt, a_rd, b_rd, a_sh, b_sh;
  logic        a_rtype, b_rtype, a_mis, b_mis, a_oob, b_oob;
  logic [3:0]  a_count;
  logic [15:0] b_count;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int cnta = 0;
  int cntb = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
    logic        oob;
    int          eno;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];

  logic [31:0] mem [64];
  logic [31:0] ra [3];
  logic [31:0] rb [3];

  initial clka = 1'b0;
  always #5 clka = ~clka;

  instr_fetch_stage #(.ADDR_W(6), .LAT(1), .CNT_W(4)) dut_a (
    .clka(clka), .rsta(rsta), .pc_in(pc_in), .flush(flush),
    .rom_addra(a_addr), .rom_douta(a_dout),
    .if_valid(a_valid), .if_pc(a_pc), .if_instr(a_instr),
    .if_op(a_op), .if_rs(a_rs), .if_rt(a_rt), .if_rd(a_rd),
    .if_shamt(a_sh), .if_funct(a_funct), .if_rtype(a_rtype),
    .if_misalign(a_mis), .if_oob(a_oob), .if_count(a_count)
  );

  instr_fetch_stage #(.ADDR_W(6), .LAT(3), .CNT_W(16)) dut_b (
    .clka(clka), .rsta(rsta), .pc_in(pc_in), .flush(flush),
    .rom_addra(b_addr), .rom_douta(b_dout),
    .if_valid(b_valid), .if_pc(b_pc), .if_instr(b_instr),
    .if_op(b_op), .if_rs(b_rs), .if_rt(b_rt), .if_rd(b_rd),
    .if_shamt(b_sh), .if_funct(b_funct), .if_rtype(b_rtype),
    .if_misalign(b_mis), .if_oob(b_oob), .if_count(b_count)
  );

  // Synchronous ROM models with 1 and 3 edges of latency.
  always @(posedge clka) begin
    ra[0] <= mem[a_addr];
    ra[1] <= ra[0];
    ra[2] <= ra[1];
    rb[0] <= mem[b_addr];
    rb[1] <= rb[0];
    rb[2] <= rb[1];
  end
  assign a_dout = ra[0];
  assign b_dout = rb[2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.pc    = pc;
    e.mis   = (pc[1:0] != 2'b00);
    e.oob   = (pc[31:8] != 24'd0);
    e.instr = (e.mis || e.oob) ? 32'd0 : mem[pc[7:2]];
    e.eno   = edge_no;
    return e;
  endfunction

  // Present pc/flush for one edge, then update the scoreboards: a flush
  // kills the LAT entries still in flight plus the one captured now.
  task automatic step(input logic [31:0] pc, input logic fl);
    pc_in = pc;
    flush = fl;
    @(posedge clka);
    #1;
    edge_no++;
    if (fl) begin
      while (qa.size() > 0 && qa[$].eno >= edge_no - 1) void'(qa.pop_back());
      while (qb.size() > 0 && qb[$].eno >= edge_no - 3) void'(qb.pop_back());
    end else begin
      qa.push_back(mk(pc));
      qb.push_back(mk(pc));
    end
  endtask

  always @(negedge clka) begin
    ent_t e;
    if (rsta) begin
      cnta = 0;
    end else if (a_valid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", a_pc, 32'hDEAD_BEEF);
      end else begin
        e = qa.pop_front();
        if (!e.mis && !e.oob && cnta < 15) cnta++;
        chk("a_pc", a_pc, e.pc);
        chk("a_instr", a_instr, e.instr);
        chk("a_fields", {a_op, a_rs, a_rt, a_rd, a_sh, a_funct}, e.instr);
        chk("a_rtype", 32'(a_rtype), 32'(e.instr[31:26] == 6'd0));
        chk("a_flags", {a_mis, a_oob}, {e.mis, e.oob});
        chk("a_count", 32'(a_count), cnta);
      end
    end
  end

  always @(negedge clka) begin
    ent_t e;
    if (rsta) begin
      cntb = 0;
    end else if (b_valid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", b_pc, 32'hDEAD_BEEF);
      end else begin
        e = qb.pop_front();
        if (!e.mis && !e.oob && cntb < 65535) cntb++;
        chk("b_pc", b_pc, e.pc);
        chk("b_instr", b_instr, e.instr);
        chk("b_fields", {b_op, b_rs, b_rt, b_rd, b_sh, b_funct}, e.instr);
        chk("b_flags", {b_mis, b_oob}, {e.mis, e.oob});
        chk("b_count", 32'(b_count), cntb);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = (i << 26) | (i * 32'h0001_0841);
    mem[0] = 32'h0022_1820;
    mem[1] = 32'h8C01_0004;
    mem[2] = 32'h0000_0000;
    mem[3] = 32'h0109_4022;

    rsta  = 1'b1;
    pc_in = 32'd0;
    flush = 1'b0;
    repeat (3) @(posedge clka);
    #1;
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_a_pc", a_pc, 32'd0);
    chk("rst_a_instr", a_instr, 32'd0);
    chk("rst_a_count", 32'(a_count), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_b_flags", {b_mis, b_oob}, 32'd0);
    chk("rst_addr0", 32'(a_addr), 32'd0);
    pc_in = 32'h3C;
    #1;
    chk("addr_3c", 32'(a_addr), 32'd15);
    pc_in = 32'd0;
    @(negedge clka);
    rsta = 1'b0;

    step(32'h0, 1'b0);
    step(32'h4, 1'b0);
    chk("e2_valid", 32'(a_valid), 32'd1);
    chk("e2_pc", a_pc, 32'd0);
    chk("e2_instr", a_instr, 32'h0022_1820);
    chk("e2_rs", 32'(a_rs), 32'd1);
    chk("e2_rt", 32'(a_rt), 32'd2);
    chk("e2_rd", 32'(a_rd), 32'd3);
    chk("e2_funct", 32'(a_funct), 32'h20);
    chk("e2_rtype", 32'(a_rtype), 32'd1);
    chk("e2_b_valid", 32'(b_valid), 32'd0);
    step(32'h8, 1'b0);
    chk("e3_pc", a_pc, 32'd4);
    chk("e3_rtype", 32'(a_rtype), 32'd0);
    chk("e3_count", 32'(a_count), 32'd2);
    step(32'hC, 1'b0);
    chk("e4_b_valid", 32'(b_valid), 32'd1);
    chk("e4_b_pc", b_pc, 32'd0);
    chk("e4_count", 32'(a_count), 32'd3);

    step(32'h10, 1'b1);
    chk("fl_valid0", 32'(a_valid), 32'd0);
    chk("fl_count0", 32'(a_count), 32'd3);
    step(32'h14, 1'b0);
    chk("fl_valid1", 32'(a_valid), 32'd0);
    chk("fl_count1", 32'(a_count), 32'd3);
    step(32'h18, 1'b0);
    chk("fl_resume_pc", a_pc, 32'h14);
    chk("fl_resume_cnt", 32'(a_count), 32'd4);

    for (int p = 32'h1C; p <= 32'h3C; p += 4) step(32'(p), 1'b0);
    step(32'h100, 1'b0);
    step(32'h102, 1'b0);
    chk("oob_valid", 32'(a_valid), 32'd1);
    chk("oob_flag", {a_mis, a_oob}, 32'b01);
    chk("oob_instr", a_instr, 32'd0);
    chk("oob_count", 32'(a_count), 32'd14);
    step(32'hFFFF_FFFC, 1'b0);
    chk("mis_oob_flag", {a_mis, a_oob}, 32'b11);
    chk("mis_oob_count", 32'(a_count), 32'd14);
    step(32'h0, 1'b0);
    chk("wrap_pc", a_pc, 32'hFFFF_FFFC);
    for (int p = 4; p <= 32'h30; p += 4) step(32'(p), 1'b0);
    chk("sat_count", 32'(a_count), 32'd15);

    rsta = 1'b1;
    #1;
    chk("mid_a_valid", 32'(a_valid), 32'd0);
    chk("mid_a_count", 32'(a_count), 32'd0);
    chk("mid_a_fields", {a_op, a_rs, a_rt, a_rd, a_sh, a_funct}, 32'd0);
    chk("mid_b_count", 32'(b_count), 32'd0);
    qa.delete();
    qb.delete();
    pc_in = 32'd0;
    repeat (2) @(posedge clka);
    @(negedge clka);
    rsta = 1'b0;
    step(32'h0, 1'b0);
    chk("re_e1_valid", 32'(a_valid), 32'd0);
    step(32'h4, 1'b0);
    chk("re_e2_pc", a_pc, 32'd0);
    chk("re_e2_valid", 32'(a_valid), 32'd1);
    step(32'h8, 1'b0);
    chk("re_e3_b_valid", 32'(b_valid), 32'd0);
    step(32'hC, 1'b0);
    chk("re_e4_b_pc", b_pc, 32'd0);
    chk("re_e4_b_valid", 32'(b_valid), 32'd1);
    for (int p = 32'h10; p <= 32'h1C; p += 4) step(32'(p), 1'b0);

    repeat (4) step(32'h20, 1'b1);
    @(negedge clka);
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction fetch stage of the E8 R-type CPU, directly downstream of the program counter. It takes the free-running byte address from the PC, drives the synchronous instruction ROM, and re-aligns the returned word with its PC through a latency-matched pipeline. It registers the instruction and its pre-split R-type fields for the decode stage. It also flags misaligned or out-of-range fetches and counts good instructions delivered.

## Interface
- ADDR_W, 6, ROM word-address width (ROM depth 2^ADDR_W words)
- LAT, 1, ROM read latency in clka edges, legal 1..3
- CNT_W, 16, width of delivered-instruction counter
- clka  in  1  clock, all state on rising edge
- rsta  in  1  reset, asynchronous, active-high; clears all state immediately
- pc_in  in  32  byte address from program counter
- flush  in  1  synchronous kill of all in-flight fetches
- rom_addra  out  ADDR_W  ROM word address = pc_in[ADDR_W+1:2], combinational
- rom_douta  in  32  ROM read data, valid LAT edges after address
- if_valid  out  1  if_* outputs hold a fetched instruction this cycle
- if_pc  out  32  byte address of if_instr
- if_instr  out  32  fetched word (0 when errored)
- if_op / if_rs / if_rt / if_rd / if_shamt / if_funct  out  6/5/5/5/5/6  fields [31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0] of if_instr
- if_rtype  out  1  if_valid && if_op==0
- if_misalign  out  1  pc_in[1:0]!=0 for this entry
- if_oob  out  1  pc_in[31:ADDR_W+2]!=0 for this entry
- if_count  out  CNT_W  good instructions delivered, saturating

## Operation
- Tag pipeline, depth LAT, entries {pc, v, mis, oob}; each edge pipe[0] <= {pc_in, 1, mis(pc_in), oob(pc_in)}, pipe[k] <= pipe[k-1].
- Output register captures each edge from pipe[LAT-1] and rom_douta: if_valid <= pipe[LAT-1].v, if_pc <= pipe[LAT-1].pc, if_instr <= (mis|oob) ? 0 : rom_douta, error flags copied.
- Fields are slices of the registered if_instr; no extra state.
- Only one error path: mis and oob may both be set; both flags report, instr = 0.
- if_count increments on each edge that loads if_valid=1 with mis=0 and oob=0; holds at 2^CNT_W-1.
- flush=1 at an edge: all pipe v bits <= 0, if_valid <= 0, including the pc_in captured at that edge. if_count is not changed by a flushed entry. Next edge with flush=0 resumes normally.
- No backpressure: PC advances every cycle; this stage never stalls.

## Timing
- Reset: all pipe entries 0, if_valid/if_pc/if_instr/all fields/flags 0, if_count 0. rom_addra follows pc_in (0 while PC is in reset).
- Latency pc_in -> if_*: LAT+1 edges. First if_valid=1 (pc 0) after edge LAT+1 following rsta release.
- Steady state: one instruction per cycle, if_pc increments by 4 per cycle.
- if_pc wraps with pc_in: 0xFFFFFFFC -> 0 is carried unchanged. Addresses at or above 4·2^ADDR_W raise oob.
- rsta mid-stream: outputs clear asynchronously, in-flight entries are lost, and the restart sequence is identical to power-up.
- flush and rsta together: rsta dominates.

## Test plan
- LAT=1, ROM[0..3]=0x00221820,0x8C010004,0x00000000,0x01094022; release rsta -> edge 2: if_valid=1, if_pc=0, if_instr=0x00221820, if_rs=1, if_rt=2, if_rd=3, if_funct=0x20, if_rtype=1. Edge 3: if_pc=4, if_rtype=0 (op 0x23).
- LAT=3: same ROM -> first if_valid at edge 4 with if_pc=0. Thereafter if_pc/if_instr pair matches ROM every cycle.
- flush pulse one cycle while pc_in=0x10, LAT=1 -> if_valid=0 for the entries at pc 0xC and 0x10. Next valid if_pc=0x14, if_count unchanged across the gap.
- ADDR_W=6, drive pc_in=0x100 -> if_oob=1, if_instr=0, if_valid=1, if_count not incremented. pc_in=0x102 -> if_misalign=1 and if_oob=1.
- CNT_W=4, 20 good fetches -> if_count climbs to 15 and holds at 15.
- Assert rsta mid-stream with if_count=7 -> same cycle if_valid=0, if_count=0, all fields 0. After release, first valid after LAT+1 edges at if_pc=0.
